cpu_lsu_port: RTL



---
 rtl/cpu_lsu_port.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_lsu_port.sv
`default_nettype none
// ============================================================================
// Module   : cpu_lsu_port
// Purpose  : Load/store unit port between a CPU pipeline and a byte-lane data
//            memory. Accepts one request at a time in IDLE. It drives a read
//            (DM_OE) or a byte-masked write (DM_WEB/DM_DI) until the memory
//            completes, then returns a one-cycle response with the load data
//            aligned and sign/zero-extended.
// Option   : LSU_MISALIGN_CHK_EN - when defined, a request whose address is
//            not a multiple of its size skips the memory. It responds with
//            rsp_err=1 and rsp_rdata=0. When undefined, rsp_err is always 0
//            and the offset is truncated down to the size boundary.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//            req_wdata  - pipeline request
//            rsp_valid/rsp_rdata/rsp_err - one-cycle completion
//            lsu_stall  - pipeline hold
//            DM_OE/DM_WEB/DM_A/DM_DI/DM_DO/DM_Stall/DM_rDone - memory side
// Revision : 1.0 - initial release
// ============================================================================
module cpu_lsu_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                lsu_stall,
    output logic                DM_OE,
    output logic [DATA_W/8-1:0] DM_WEB,
    output logic [ADDR_W-1:0]   DM_A,
    output logic [DATA_W-1:0]   DM_DI,
    input  logic [DATA_W-1:0]   DM_DO,
    input  logic                DM_Stall,
    input  logic                DM_rDone
);
    localparam int c_nb    = DATA_W / 8;
    localparam int c_off_w = $clog2(c_nb);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [c_off_w-1:0] r_off;

    logic [1:0]         w_size;
    logic [c_off_w-1:0] w_off_raw;
    logic [c_off_w-1:0] w_align;
    logic [c_off_w-1:0] w_off;
    logic [c_nb-1:0]    w_unit;
    logic [c_nb-1:0]    w_lanes;
    logic [ADDR_W-1:0]  w_base;
    logic [DATA_W-1:0]  w_wrep;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_ext;
    logic               w_err;

    // A dword on a 32-bit memory is treated as a full word.
    assign w_size    = (c_nb == 4 && req_size == 2'd3) ? 2'd2 : req_size;
    assign w_off_raw = req_addr[c_off_w-1:0];
    assign w_base    = {req_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};

    // w_align holds the offset bits that must be zero for the size. The unit
    // mask marks the lanes covered by the size, starting at lane 0.
    always_comb begin
        w_align = '0;
        w_unit  = c_nb'(8'h01);
        w_wrep  = {c_nb{req_wdata[7:0]}};
        case (w_size)
            2'd0: begin
                w_align = '0;
                w_unit  = c_nb'(8'h01);
                w_wrep  = {c_nb{req_wdata[7:0]}};
            end
            2'd1: begin
                w_align = c_off_w'(3'd1);
                w_unit  = c_nb'(8'h03);
                w_wrep  = {(c_nb/2){req_wdata[15:0]}};
            end
            2'd2: begin
                w_align = c_off_w'(3'd3);
                w_unit  = c_nb'(8'h0F);
                w_wrep  = {(c_nb/4){req_wdata[31:0]}};
            end
            default: begin
                w_align = c_off_w'(3'd7);
                w_unit  = c_nb'(8'hFF);
                w_wrep  = req_wdata;
            end
        endcase
    end

    // Misaligned offsets are truncated down to the size boundary.
    assign w_off   = w_off_raw & ~w_align;
    assign w_lanes = w_unit << w_off;

`ifdef LSU_MISALIGN_CHK_EN
    assign w_err = |(w_off_raw & w_align);
`else
    assign w_err = 1'b0;
`endif

    // Load path: shift the addressed unit down to bit 0, then extend.
    assign w_shift = DM_DO >> {r_off, 3'b000};

    generate
        if (DATA_W == 32) begin : g_word32
            assign w_word = w_shift;
        end else begin : g_word64
            assign w_word = {{(DATA_W-32){~r_unsigned & w_shift[31]}}, w_shift[31:0]};
        end
    endgenerate

    always_comb begin
        w_ext = w_shift;
        case (r_size)
            2'd0:    w_ext = {{(DATA_W-8){~r_unsigned & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ext = {{(DATA_W-16){~r_unsigned & w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_ext = w_word;
            default: w_ext = w_shift;
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign lsu_stall = (req_valid & ~req_ready) | (r_state == RD_WAIT) | (r_state == WR_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_off      <= '0;
            DM_OE      <= 1'b0;
            DM_WEB     <= '1;
            DM_A       <= '0;
            DM_DI      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_size     <= w_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_off;
                        if (w_err) begin
                            // Rejected without touching memory.
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            r_state <= WR_WAIT;
                            DM_A    <= w_base;
                            DM_WEB  <= ~w_lanes;
                            DM_DI   <= w_wrep;
                        end else begin
                            r_state <= RD_WAIT;
                            DM_A    <= w_base;
                            DM_OE   <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    // DM_Stall is deliberately not looked at here.
                    if (DM_rDone) begin
                        r_state   <= RESP;
                        DM_OE     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= w_ext;
                    end
                end
                WR_WAIT: begin
                    if (!DM_Stall) begin
                        r_state   <= RESP;
                        DM_WEB    <= '1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
